inst_fetch: RTL and testbench

//  Fetch stage between the PC register and decode. Issues instruction-bus reads at pc_i,

---
 rtl/inst_fetch_pkg.sv | 32 +++
 rtl/fetch_fifo.sv | 60 ++++++
 rtl/inst_fetch.sv | 187 ++++++++++++++++++
 tb/tb_inst_fetch.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared constants and types for the instruction fetch stage (inst_fetch, fetch_fifo).
package inst_fetch_pkg;

   localparam int unsigned INST_ADDR_BUS = 32;
   localparam int unsigned INST_REG_DATA = 32;
   localparam logic [INST_REG_DATA-1:0] INST_NOP = 32'h0000_0013;

   typedef enum logic [2:0] {
      HOLD_NONE = 3'b000,
      HOLD_PC   = 3'b001,
      HOLD_IF   = 3'b010,
      HOLD_ID   = 3'b011
   } hold_e;

   typedef enum logic [2:0] {
      SRC_KEEP,
      SRC_FIFO,
      SRC_BYPASS,
      SRC_NOP,
      SRC_MISALIGN
   } out_src_e;

   typedef struct packed {
      logic [INST_ADDR_BUS-1:0] addr;
      logic [INST_REG_DATA-1:0] inst;
   } fetch_word_t;

   function automatic int unsigned cnt_width(input int unsigned n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush and occupancy count; head is visible on dout without popping.
module fetch_fifo
   import inst_fetch_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          push,
   input  logic                          pop,
   input  logic                          flush,
   input  logic [WIDTH-1:0]              din,
   output logic [WIDTH-1:0]              dout,
   output logic [cnt_width(DEPTH)-1:0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = cnt_width(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic             empty;
   logic             full;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   // A push into a full FIFO is accepted when the head leaves in the same cycle.
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: issues instruction-bus reads at pc_i, buffers responses and drives one registered
// instruction to decode. Optional misaligned-PC trap output under `define INST_MISALIGN_CHK_EN.
module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH      = 2,
   parameter int unsigned MAX_OUTSTANDING = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [INST_ADDR_BUS-1:0] pc_i,
   input  logic [2:0]               hold_flag_i,
   input  logic                     jump_flag_i,
   output logic                     ibus_req_o,
   output logic [INST_ADDR_BUS-1:0] ibus_addr_o,
   input  logic                     ibus_gnt_i,
   input  logic                     ibus_rvalid_i,
   input  logic [INST_REG_DATA-1:0] ibus_rdata_i,
   output logic                     fetch_hold_o,
   output logic                     inst_valid_o,
   output logic [INST_REG_DATA-1:0] inst_o,
   output logic [INST_ADDR_BUS-1:0] inst_addr_o
`ifdef INST_MISALIGN_CHK_EN
   ,
   output logic                     inst_misalign_o
`endif
);

   localparam int unsigned OW = cnt_width(MAX_OUTSTANDING);
   localparam int unsigned CW = cnt_width(FIFO_DEPTH);

   logic [OW-1:0]            outstanding;
   logic [OW-1:0]            drop_cnt;

   logic                     buf_push;
   logic                     buf_pop;
   fetch_word_t              buf_dout;
   logic [CW-1:0]            buf_cnt;

   logic [INST_ADDR_BUS-1:0] aq_dout;
   logic [CW-1:0]            aq_cnt;

   logic                     misalign;
   logic                     granted;
   logic                     resp_drop;
   logic                     resp_live;
   logic                     load_en;
   fetch_word_t              resp_word;
   out_src_e                 src;

`ifdef INST_MISALIGN_CHK_EN
   assign misalign    = (pc_i[1:0] != 2'b00);
   assign ibus_addr_o = pc_i;
`else
   assign misalign    = 1'b0;
   assign ibus_addr_o = pc_i & 32'hFFFF_FFFC;
`endif

   // Buffer space is reserved at grant time so a response can always be stored.
   assign ibus_req_o = !rst && !jump_flag_i && !misalign
                       && (hold_flag_i < HOLD_PC)
                       && (32'(outstanding) < MAX_OUTSTANDING)
                       && (32'(buf_cnt) + 32'(outstanding) < FIFO_DEPTH);

   assign granted      = ibus_req_o && ibus_gnt_i;
   assign fetch_hold_o = !granted;

   assign resp_drop = ibus_rvalid_i && (drop_cnt != '0);
   assign resp_live = ibus_rvalid_i && (drop_cnt == '0) && (aq_cnt != '0);
   assign resp_word = '{addr: aq_dout, inst: ibus_rdata_i};
   assign load_en   = !inst_valid_o || (hold_flag_i < HOLD_IF);

   always_comb begin
      src      = SRC_KEEP;
      buf_push = 1'b0;
      buf_pop  = 1'b0;
      if (jump_flag_i) begin
         src = SRC_NOP;
      end else if (load_en) begin
         if (buf_cnt != '0) begin
            src      = SRC_FIFO;
            buf_pop  = 1'b1;
            buf_push = resp_live;
         end else if (resp_live) begin
            src = SRC_BYPASS;
         end else if (misalign && outstanding == '0) begin
            src = SRC_MISALIGN;
         end else begin
            src = SRC_NOP;
         end
      end else begin
         buf_push = resp_live;
      end
   end

   fetch_fifo #(
      .WIDTH ($bits(fetch_word_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_inst_buf (
      .clk   (clk),
      .rst   (rst),
      .push  (buf_push),
      .pop   (buf_pop),
      .flush (jump_flag_i),
      .din   (resp_word),
      .dout  (buf_dout),
      .count (buf_cnt)
   );

   fetch_fifo #(
      .WIDTH (INST_ADDR_BUS),
      .DEPTH (FIFO_DEPTH)
   ) u_addr_queue (
      .clk   (clk),
      .rst   (rst),
      .push  (granted),
      .pop   (resp_live),
      .flush (jump_flag_i),
      .din   (ibus_addr_o),
      .dout  (aq_dout),
      .count (aq_cnt)
   );

   // Responses still in flight at a jump are counted out and discarded as they arrive.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         outstanding <= '0;
         drop_cnt    <= '0;
      end else begin
         outstanding <= outstanding + OW'(granted) - OW'(ibus_rvalid_i);
         if (jump_flag_i)
            drop_cnt <= outstanding - OW'(ibus_rvalid_i);
         else if (resp_drop)
            drop_cnt <= drop_cnt - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inst_valid_o <= 1'b0;
         inst_o       <= INST_NOP;
         inst_addr_o  <= '0;
      end else begin
         case (src)
            SRC_FIFO: begin
               inst_valid_o <= 1'b1;
               inst_o       <= buf_dout.inst;
               inst_addr_o  <= buf_dout.addr;
            end
            SRC_BYPASS: begin
               inst_valid_o <= 1'b1;
               inst_o       <= resp_word.inst;
               inst_addr_o  <= resp_word.addr;
            end
            SRC_MISALIGN: begin
               inst_valid_o <= 1'b1;
               inst_o       <= INST_NOP;
               inst_addr_o  <= pc_i;
            end
            SRC_NOP: begin
               inst_valid_o <= 1'b0;
               inst_o       <= INST_NOP;
            end
            default: ;
         endcase
      end
   end

`ifdef INST_MISALIGN_CHK_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inst_misalign_o <= 1'b0;
      end else begin
         case (src)
            SRC_MISALIGN:                  inst_misalign_o <= 1'b1;
            SRC_FIFO, SRC_BYPASS, SRC_NOP: inst_misalign_o <= 1'b0;
            default: ;
         endcase
      end
   end
`endif

   a_rvalid_has_request: assert property (
      @(posedge clk) disable iff (rst) ibus_rvalid_i |-> (outstanding != '0)
   );

endmodule

// File: tb/tb_inst_fetch.sv
// Randomized bench for inst_fetch: queue-based reference model plus a variable-latency bus slave.
module tb_inst_fetch;
   import inst_fetch_pkg::*;

   localparam int unsigned DEPTH = 2;
   localparam int unsigned MAXO  = 2;
   localparam int unsigned NCYC  = 3000;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_i;
   logic [2:0]  hold_flag_i;
   logic        jump_flag_i;
   logic        ibus_req_o;
   logic [31:0] ibus_addr_o;
   logic        ibus_gnt_i;
   logic        ibus_rvalid_i;
   logic [31:0] ibus_rdata_i;
   logic        fetch_hold_o;
   logic        inst_valid_o;
   logic [31:0] inst_o;
   logic [31:0] inst_addr_o;

   inst_fetch #(
      .FIFO_DEPTH      (DEPTH),
      .MAX_OUTSTANDING (MAXO)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .pc_i          (pc_i),
      .hold_flag_i   (hold_flag_i),
      .jump_flag_i   (jump_flag_i),
      .ibus_req_o    (ibus_req_o),
      .ibus_addr_o   (ibus_addr_o),
      .ibus_gnt_i    (ibus_gnt_i),
      .ibus_rvalid_i (ibus_rvalid_i),
      .ibus_rdata_i  (ibus_rdata_i),
      .fetch_hold_o  (fetch_hold_o),
      .inst_valid_o  (inst_valid_o),
      .inst_o        (inst_o),
      .inst_addr_o   (inst_addr_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
   endfunction

   // Reference model: requests in flight (with drop mark), buffered words, and the decode register.
   typedef struct {
      logic [31:0] addr;
      bit          drop;
   } flight_t;
   typedef struct {
      logic [31:0] addr;
      int          t;
   } bus_t;

   flight_t     flight[$];
   fetch_word_t pend[$];
   bit          m_valid;
   logic [31:0] m_inst;
   logic [31:0] m_addr;
   bus_t        bus_q[$];
   logic [31:0] pc;
   int          cyc;
   int          hold_burst;

   task automatic model_reset();
      flight.delete();
      pend.delete();
      bus_q.delete();
      m_valid = 1'b0;
      m_inst  = INST_NOP;
      m_addr  = '0;
      pc      = '0;
      hold_burst = 0;
   endtask

   task automatic quiet_inputs();
      hold_flag_i   = HOLD_NONE;
      jump_flag_i   = 1'b0;
      ibus_gnt_i    = 1'b0;
      ibus_rvalid_i = 1'b0;
      ibus_rdata_i  = '0;
      pc_i          = '0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req"},        32'(ibus_req_o),   32'd0);
      check({tag, "_fetch_hold"}, 32'(fetch_hold_o), 32'd1);
      check({tag, "_valid"},      32'(inst_valid_o), 32'd0);
      check({tag, "_inst"},       inst_o,            INST_NOP);
      check({tag, "_inst_addr"},  inst_addr_o,       32'd0);
   endtask

   task automatic run_cycle();
      bit          exp_req;
      bit          w_ok;
      fetch_word_t w;
      flight_t     f;
      bus_t        b;

      @(posedge clk);
      #1;
      cyc++;
      check("inst_valid", 32'(inst_valid_o), 32'(m_valid));
      check("inst",       inst_o,            m_inst);
      check("inst_addr",  inst_addr_o,       m_addr);

      if (hold_burst > 0) begin
         hold_burst--;
         hold_flag_i = ($urandom_range(0, 3) == 0) ? 3'(HOLD_ID) : 3'(HOLD_IF);
      end else if ($urandom_range(0, 19) == 0) begin
         hold_burst  = $urandom_range(3, 6);
         hold_flag_i = HOLD_IF;
      end else begin
         hold_flag_i = ($urandom_range(0, 7) == 0) ? 3'(HOLD_PC) : 3'(HOLD_NONE);
      end
      jump_flag_i   = ($urandom_range(0, 11) == 0);
      ibus_gnt_i    = ($urandom_range(0, 3) != 0);
      ibus_rvalid_i = 1'b0;
      ibus_rdata_i  = $urandom;
      if (bus_q.size() > 0 && bus_q[0].t < cyc && $urandom_range(0, 9) < 7) begin
         ibus_rvalid_i = 1'b1;
         ibus_rdata_i  = mem_word(bus_q[0].addr);
      end
      pc_i = pc | (($urandom_range(0, 9) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
      #1;

      exp_req = !jump_flag_i && (hold_flag_i == 3'd0) && (flight.size() < MAXO)
                && (pend.size() + flight.size() < DEPTH);
      check("req",        32'(ibus_req_o),   32'(exp_req));
      check("fetch_hold", 32'(fetch_hold_o), 32'(!(exp_req && ibus_gnt_i)));
      if (exp_req) check("ibus_addr", ibus_addr_o, pc);

      // bus slave bookkeeping follows what the DUT actually does on the bus
      if (ibus_rvalid_i) void'(bus_q.pop_front());
      if (ibus_req_o && ibus_gnt_i) begin
         b.addr = ibus_addr_o;
         b.t    = cyc;
         bus_q.push_back(b);
      end

      w_ok = 1'b0;
      if (ibus_rvalid_i && flight.size() > 0) begin
         f = flight.pop_front();
         if (!f.drop) begin
            w.addr = f.addr;
            w.inst = mem_word(f.addr);
            w_ok   = 1'b1;
         end
      end

      if (jump_flag_i) begin
         pend.delete();
         foreach (flight[i]) flight[i].drop = 1'b1;
         m_valid = 1'b0;
         m_inst  = INST_NOP;
         pc      = 32'h0000_1000 + 32'($urandom_range(0, 63)) * 4;
      end else begin
         if (w_ok) pend.push_back(w);
         if (!m_valid || hold_flag_i < 3'(HOLD_IF)) begin
            if (pend.size() > 0) begin
               w       = pend.pop_front();
               m_valid = 1'b1;
               m_inst  = w.inst;
               m_addr  = w.addr;
            end else begin
               m_valid = 1'b0;
               m_inst  = INST_NOP;
            end
         end
         if (exp_req && ibus_gnt_i) begin
            f.addr = pc;
            f.drop = 1'b0;
            flight.push_back(f);
            pc += 32'd4;
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      quiet_inputs();
      model_reset();
      cyc = 0;
      #1;
      check_reset_outputs("por");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      for (int unsigned n = 0; n < NCYC; n++) begin
         run_cycle();
         if (n == NCYC / 2) begin
            // asynchronous reset in the middle of traffic
            #1;
            rst = 1'b1;
            #1;
            check_reset_outputs("async_rst");
            quiet_inputs();
            model_reset();
            @(posedge clk);
            #1;
            check_reset_outputs("rst_held");
            @(negedge clk);
            rst = 1'b0;
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
